// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with input FIFO and break generation.
// Ports: clk/rst (async, active-high); in_data/in_valid/in_ready push stream;
// cfg_div, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_two_stop, cfg_break line format;
// tx serial line, busy, frame_done pulse, fifo_level occupancy.
// Optional: define UART_TX_CTS_EN to add cts_n (active-low clear-to-send) gating FIFO pops.
module uart_tx_cfg #(
  parameter int FifoDepth   = 4,
  parameter int DivWidth    = 16,
  parameter int MaxDataBits = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MaxDataBits-1:0]       in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DivWidth-1:0]          cfg_div,
  input  logic [3:0]                   cfg_data_bits,
  input  logic                         cfg_parity_en,
  input  logic                         cfg_parity_odd,
  input  logic                         cfg_two_stop,
  input  logic                         cfg_break,
`ifdef UART_TX_CTS_EN
  input  logic                         cts_n,
`endif
  output logic                         tx,
  output logic                         busy,
  output logic                         frame_done,
  output logic [$clog2(FifoDepth):0]   fifo_level
);
  localparam int AW = $clog2(FifoDepth);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t r_state, w_next;
  logic [MaxDataBits-1:0] r_mem [FifoDepth];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic [DivWidth-1:0] r_div, r_dcnt;
  logic [3:0] r_nbits, r_bcnt, w_nbits;
  logic [MaxDataBits-1:0] r_shift, w_mask;
  logic r_par_en, r_par, r_two, r_brel;
  logic w_push, w_pop, w_tick, w_dec, w_cts_ok, w_stop_last;
`ifdef UART_TX_CTS_EN
  logic r_cts_s1, r_cts_s2;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_cts_s2, r_cts_s1} <= 2'b11;
    else {r_cts_s2, r_cts_s1} <= {r_cts_s1, cts_n};
  assign w_cts_ok = !r_cts_s2;
`else
  assign w_cts_ok = 1'b1;
`endif
  assign in_ready    = r_cnt != (AW+1)'(FifoDepth);
  assign w_push      = in_valid && in_ready;
  assign w_tick      = r_dcnt == r_div;
  assign w_stop_last = !r_two || r_bcnt == 4'd1;
  // The last stop clock doubles as an IDLE decision so back-to-back frames have no gap.
  assign w_dec       = r_state == IDLE || (r_state == STOP && w_tick && w_stop_last);
  assign w_pop       = w_dec && !cfg_break && r_cnt != '0 && w_cts_ok;
  assign w_nbits     = cfg_data_bits < 4'd5 ? 4'd5 :
                       cfg_data_bits > 4'(MaxDataBits) ? 4'(MaxDataBits) : cfg_data_bits;
  assign fifo_level  = r_cnt;
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MaxDataBits; i++) w_mask[i] = i < int'(w_nbits);
  end
  always_comb begin
    w_next     = r_state;
    busy       = r_state != IDLE;
    frame_done = r_state == STOP && w_tick && w_stop_last;
    tx         = r_state == START  ? 1'b0 :
                 r_state == DATA   ? r_shift[0] :
                 r_state == PARITY ? r_par :
                 r_state == BREAK  ? r_brel : 1'b1;
    if (w_dec) w_next = cfg_break ? BREAK : w_pop ? START : IDLE;
    else if (w_tick)
      w_next = r_state == START  ? DATA :
               r_state == DATA   ? (r_bcnt == r_nbits - 4'd1 ? (r_par_en ? PARITY : STOP) : DATA) :
               r_state == PARITY ? STOP :
               (r_state == BREAK && r_brel) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_div    <= '0;
      r_dcnt   <= '0;
      r_nbits  <= 4'd5;
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_two    <= 1'b0;
      r_brel   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt  <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      // While break holds the line low the divider idles; release timing starts at zero.
      r_dcnt <= (w_pop || w_tick || r_state == IDLE || (r_state == BREAK && !r_brel)) ? '0 : r_dcnt + 1'b1;
      r_bcnt <= (w_pop || (w_tick && w_next != r_state)) ? '0 : w_tick ? r_bcnt + 1'b1 : r_bcnt;
      r_brel <= r_state == BREAK && (r_brel || !cfg_break);
      if (w_pop) begin
        r_div    <= cfg_div;
        r_nbits  <= w_nbits;
        r_par_en <= cfg_parity_en;
        r_par    <= ^(r_mem[r_rp] & w_mask) ^ cfg_parity_odd;
        r_two    <= cfg_two_stop;
        r_shift  <= r_mem[r_rp];
      end else if (r_state == DATA && w_tick) r_shift <= r_shift >> 1;
      else if (r_state == BREAK && !r_brel && !cfg_break) r_div <= cfg_div;
    end
endmodule
